// File: rtl/steal_transfer_engine_if.sv
// Request, queue pop/push and completion signals between the steal transfer engine and its neighbours.
// master = engine side, slave = steal decision logic plus queue array side.
interface steal_transfer_engine_if #(
   parameter int NUM_PIPELINES = 16,
   parameter int TASK_W        = 32,
   parameter int MAX_BATCH     = 4
);
   localparam int QID_W = $clog2(NUM_PIPELINES);
   localparam int CNT_W = $clog2(MAX_BATCH + 1);

   logic              req_valid;
   logic              req_ready;
   logic [QID_W-1:0]  req_src;
   logic [QID_W-1:0]  req_dst;
   logic [7:0]        req_src_size;

   logic              pop_req;
   logic [QID_W-1:0]  pop_qid;
   logic              pop_ack;
   logic              pop_hit;
   logic [TASK_W-1:0] pop_data;

   logic              push_valid;
   logic [QID_W-1:0]  push_qid;
   logic [TASK_W-1:0] push_data;
   logic              push_ready;

   logic              busy;
   logic              done;
   logic [CNT_W-1:0]  done_count;
   logic [1:0]        done_status;

   modport master (
      input  req_valid, req_src, req_dst, req_src_size,
      input  pop_ack, pop_hit, pop_data, push_ready,
      output req_ready, pop_req, pop_qid, push_valid, push_qid, push_data,
      output busy, done, done_count, done_status
   );

   modport slave (
      output req_valid, req_src, req_dst, req_src_size,
      output pop_ack, pop_hit, pop_data, push_ready,
      input  req_ready, pop_req, pop_qid, push_valid, push_qid, push_data,
      input  busy, done, done_count, done_status
   );
endinterface

// File: rtl/steal_transfer_engine.sv
// Moves up to MAX_BATCH tasks from a victim queue to an idle queue, one pop/push pair per 2 cycles.
// Pop and push wait indefinitely on the queues; `define STEAL_TIMEOUT_EN adds a pop-ack watchdog (status 11).
module steal_transfer_engine #(
   parameter int NUM_PIPELINES = 16,
   parameter int TASK_W        = 32,
   parameter int MAX_BATCH     = 4,
   parameter int TIMEOUT_CYC   = 64
) (
   input  logic                    clk,
   input  logic                    rst,
   steal_transfer_engine_if.master bus
);
   localparam int QID_W = $clog2(NUM_PIPELINES);
   localparam int CNT_W = $clog2(MAX_BATCH + 1);

   localparam logic [1:0] ST_FULL   = 2'b00;
   localparam logic [1:0] ST_SHORT  = 2'b01;
   localparam logic [1:0] ST_REJECT = 2'b10;

   typedef enum logic [1:0] {IDLE, POP, PUSH, DONE} state_t;

   state_t            state, state_nxt;
   logic [QID_W-1:0]  src, src_nxt;
   logic [QID_W-1:0]  dst, dst_nxt;
   logic [CNT_W-1:0]  batch, batch_nxt;
   logic [CNT_W-1:0]  moved, moved_nxt;
   logic [CNT_W-1:0]  moved_inc;
   logic [CNT_W-1:0]  dcount, dcount_nxt;
   logic [1:0]        dstatus, dstatus_nxt;
   logic [TASK_W-1:0] buffer, buffer_nxt;
   logic [7:0]        half_size;
   logic [7:0]        batch_w;

`ifdef STEAL_TIMEOUT_EN
   localparam int         TMO_W      = $clog2(TIMEOUT_CYC + 1);
   localparam logic [1:0] ST_TIMEOUT = 2'b11;
   logic [TMO_W-1:0] tmo_cnt, tmo_cnt_nxt;
   logic             tmo_hit;

   // Counter is zero whenever POP is entered; the last waiting cycle is the TIMEOUT_CYC-th pop_req cycle.
   assign tmo_hit     = (state == POP) && !bus.pop_ack && (tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));
   assign tmo_cnt_nxt = ((state == POP) && !bus.pop_ack) ? tmo_cnt + TMO_W'(1) : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) tmo_cnt <= '0;
      else     tmo_cnt <= tmo_cnt_nxt;
   end
`endif

   // Batch size is clamped at 8 bits before truncation so oversized victims never wrap to a small batch.
   assign half_size = bus.req_src_size >> 1;
   assign batch_w   = (half_size < 8'(MAX_BATCH)) ? half_size : 8'(MAX_BATCH);
   assign moved_inc = moved + CNT_W'(1);

   always_comb begin
      state_nxt   = state;
      src_nxt     = src;
      dst_nxt     = dst;
      batch_nxt   = batch;
      moved_nxt   = moved;
      dcount_nxt  = dcount;
      dstatus_nxt = dstatus;
      buffer_nxt  = buffer;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               src_nxt   = bus.req_src;
               dst_nxt   = bus.req_dst;
               batch_nxt = CNT_W'(batch_w);
               moved_nxt = '0;
               if ((batch_w == 8'd0) || (bus.req_src == bus.req_dst)) begin
                  state_nxt   = DONE;
                  dcount_nxt  = '0;
                  dstatus_nxt = ST_REJECT;
               end else begin
                  state_nxt = POP;
               end
            end
         end
         POP: begin
`ifdef STEAL_TIMEOUT_EN
            if (tmo_hit) begin
               state_nxt   = DONE;
               dcount_nxt  = moved;
               dstatus_nxt = ST_TIMEOUT;
            end else
`endif
            if (bus.pop_ack) begin
               if (bus.pop_hit) begin
                  buffer_nxt = bus.pop_data;
                  state_nxt  = PUSH;
               end else begin
                  state_nxt   = DONE;
                  dcount_nxt  = moved;
                  dstatus_nxt = ST_SHORT;
               end
            end
         end
         PUSH: begin
            if (bus.push_ready) begin
               moved_nxt = moved_inc;
               if (moved_inc == batch) begin
                  state_nxt   = DONE;
                  dcount_nxt  = moved_inc;
                  dstatus_nxt = ST_FULL;
               end else begin
                  state_nxt = POP;
               end
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         src     <= '0;
         dst     <= '0;
         batch   <= '0;
         moved   <= '0;
         dcount  <= '0;
         dstatus <= '0;
         buffer  <= '0;
      end else begin
         state   <= state_nxt;
         src     <= src_nxt;
         dst     <= dst_nxt;
         batch   <= batch_nxt;
         moved   <= moved_nxt;
         dcount  <= dcount_nxt;
         dstatus <= dstatus_nxt;
         buffer  <= buffer_nxt;
      end
   end

   // All queue-facing outputs decode from registered state only, so acks never loop back combinationally.
   assign bus.req_ready   = (state == IDLE);
   assign bus.busy        = (state != IDLE);
   assign bus.pop_req     = (state == POP);
   assign bus.pop_qid     = src;
   assign bus.push_valid  = (state == PUSH);
   assign bus.push_qid    = dst;
   assign bus.push_data   = buffer;
   assign bus.done        = (state == DONE);
   assign bus.done_count  = dcount;
   assign bus.done_status = dstatus;
endmodule

// File: tb/tb_steal_transfer_engine.sv
// Directed bench for steal_transfer_engine: a reactive queue responder drives acks, expectations are hand-computed.
module tb_steal_transfer_engine;
`ifdef STEAL_TIMEOUT_EN
   localparam int TMO = 8;
`else
   localparam int TMO = 64;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   steal_transfer_engine_if #(.NUM_PIPELINES(16), .TASK_W(32), .MAX_BATCH(4)) bus ();

   steal_transfer_engine #(
      .NUM_PIPELINES(16), .TASK_W(32), .MAX_BATCH(4), .TIMEOUT_CYC(TMO)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.req_valid    = 1'b0;
      bus.req_src      = '0;
      bus.req_dst      = '0;
      bus.req_src_size = '0;
      bus.pop_ack      = 1'b0;
      bus.pop_hit      = 1'b0;
      bus.pop_data     = '0;
      bus.push_ready   = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "/req_ready"},   32'(bus.req_ready),   32'd1);
      check_val({tag, "/pop_req"},     32'(bus.pop_req),     32'd0);
      check_val({tag, "/push_valid"},  32'(bus.push_valid),  32'd0);
      check_val({tag, "/busy"},        32'(bus.busy),        32'd0);
      check_val({tag, "/done"},        32'(bus.done),        32'd0);
      check_val({tag, "/done_count"},  32'(bus.done_count),  32'd0);
      check_val({tag, "/done_status"}, 32'(bus.done_status), 32'd0);
      check_val({tag, "/pop_qid"},     32'(bus.pop_qid),     32'd0);
      check_val({tag, "/push_qid"},    32'(bus.push_qid),    32'd0);
      check_val({tag, "/push_data"},   bus.push_data,        32'd0);
   endtask

   // miss_at: pop index answered with pop_hit=0 (-1 = never); stall_at/stall_len: push index held off and for how long.
   task automatic run_txn(input string tag, input logic [3:0] s, input logic [3:0] d, input logic [7:0] sz,
                          input int miss_at, input int stall_at, input int stall_len,
                          input int exp_cnt, input logic [1:0] exp_st, input int exp_cyc);
      int pops = 0;
      int pushes = 0;
      int push_cyc = 0;
      int cyc = 0;
      int stall_left;
      int exp_pops;
      bit fin = 1'b0;
      stall_left = stall_len;
      exp_pops = (exp_st == 2'b10) ? 0 : (exp_st == 2'b01) ? exp_cnt + 1 : exp_cnt;
      check_val({tag, "/ready_before"}, 32'(bus.req_ready), 32'd1);
      bus.req_valid    = 1'b1;
      bus.req_src      = s;
      bus.req_dst      = d;
      bus.req_src_size = sz;
      // Acks coinciding with the request must have no effect.
      bus.pop_ack      = 1'b1;
      bus.pop_hit      = 1'b1;
      bus.push_ready   = 1'b1;
      tick();
      bus.req_valid    = 1'b0;
      bus.req_src_size = '0;
      while (!fin && cyc < 200) begin
         cyc++;
         bus.pop_ack    = 1'b0;
         bus.pop_hit    = 1'b0;
         bus.pop_data   = '0;
         bus.push_ready = 1'b0;
         check_val({tag, "/pop_push_excl"}, 32'(bus.pop_req & bus.push_valid), 32'd0);
         if (bus.pop_req) begin
            check_val({tag, "/pop_qid"}, 32'(bus.pop_qid), 32'(s));
            bus.pop_ack  = 1'b1;
            bus.pop_hit  = (pops != miss_at);
            bus.pop_data = 32'hA0 + 32'(pops);
            pops++;
         end
         if (bus.push_valid) begin
            push_cyc++;
            check_val({tag, "/push_qid"},  32'(bus.push_qid), 32'(d));
            check_val({tag, "/push_data"}, bus.push_data,     32'hA0 + 32'(pushes));
            if (pushes == stall_at && stall_left > 0) begin
               stall_left--;
            end else begin
               bus.push_ready = 1'b1;
               pushes++;
            end
         end
         if (bus.done) begin
            fin = 1'b1;
            check_val({tag, "/done_cycle"},   32'(cyc),             32'(exp_cyc));
            check_val({tag, "/done_count"},   32'(bus.done_count),  32'(exp_cnt));
            check_val({tag, "/done_status"},  32'(bus.done_status), 32'(exp_st));
            check_val({tag, "/ready_in_done"}, 32'(bus.req_ready),  32'd0);
            check_val({tag, "/pops"},         32'(pops),            32'(exp_pops));
            check_val({tag, "/push_cycles"},  32'(push_cyc),        32'(exp_cnt + ((stall_at >= 0 && stall_at < exp_cnt) ? stall_len : 0)));
         end else begin
            tick();
         end
      end
      if (!fin) begin
         check_val({tag, "/done_seen"}, 32'd0, 32'd1);
      end else begin
         idle_inputs();
         tick();
         check_val({tag, "/done_pulse"},  32'(bus.done),        32'd0);
         check_val({tag, "/ready_after"}, 32'(bus.req_ready),   32'd1);
         check_val({tag, "/count_held"},  32'(bus.done_count),  32'(exp_cnt));
         check_val({tag, "/status_held"}, 32'(bus.done_status), 32'(exp_st));
      end
      idle_inputs();
   endtask

   task automatic reset_during_push();
      int cyc = 0;
      bit seen = 1'b0;
      bus.req_valid    = 1'b1;
      bus.req_src      = 4'd6;
      bus.req_dst      = 4'd1;
      bus.req_src_size = 8'd4;
      tick();
      bus.req_valid = 1'b0;
      while (!seen && cyc < 20) begin
         cyc++;
         bus.pop_ack  = bus.pop_req;
         bus.pop_hit  = 1'b1;
         bus.pop_data = 32'hBB;
         if (bus.push_valid) seen = 1'b1;
         else tick();
      end
      check_val("rst_push/push_valid_seen", 32'(seen), 32'd1);
      idle_inputs();
      check_val("rst_push/push_data_pre", bus.push_data, 32'hBB);
      #2;
      rst = 1'b1;
      #1;
      check_reset_outputs("rst_push");
      tick();
      tick();
      #2;
      rst = 1'b0;
      tick();
      check_val("rst_push/ready_release", 32'(bus.req_ready), 32'd1);
   endtask

`ifdef STEAL_TIMEOUT_EN
   task automatic run_timeout();
      int cyc = 0;
      int hi = 0;
      bit fin = 1'b0;
      bus.req_valid    = 1'b1;
      bus.req_src      = 4'd1;
      bus.req_dst      = 4'd2;
      bus.req_src_size = 8'd8;
      tick();
      idle_inputs();
      while (!fin && cyc < 100) begin
         cyc++;
         if (bus.pop_req) hi++;
         if (bus.done) begin
            fin = 1'b1;
            check_val("tmo/pop_req_cycles", 32'(hi),              32'd8);
            check_val("tmo/done_cycle",     32'(cyc),             32'd9);
            check_val("tmo/done_count",     32'(bus.done_count),  32'd0);
            check_val("tmo/done_status",    32'(bus.done_status), 32'd3);
         end else begin
            tick();
         end
      end
      if (!fin) check_val("tmo/done_seen", 32'd0, 32'd1);
      tick();
   endtask
`endif

   initial begin
      idle_inputs();
      #2;
      check_reset_outputs("reset");
      #10;
      rst = 1'b0;
      tick();
      check_val("post_reset/req_ready", 32'(bus.req_ready), 32'd1);

      //       tag        src   dst   size    miss stall len cnt  status exp_cyc
      run_txn("full",     4'd3, 4'd7, 8'd10,  -1,  -1,   0,  4,   2'b00, 9);
      run_txn("short",    4'd2, 4'd5, 8'd10,   2,  -1,   0,  2,   2'b01, 6);
      run_txn("empty",    4'd1, 4'd2, 8'd10,   0,  -1,   0,  0,   2'b01, 2);
      run_txn("tiny",     4'd1, 4'd6, 8'd1,   -1,  -1,   0,  0,   2'b10, 1);
      run_txn("same",     4'd4, 4'd4, 8'd10,  -1,  -1,   0,  0,   2'b10, 1);
      run_txn("one",      4'd9, 4'd0, 8'd3,   -1,  -1,   0,  1,   2'b00, 3);
      run_txn("two",      4'd5, 4'd6, 8'd5,   -1,  -1,   0,  2,   2'b00, 5);
      run_txn("stall",    4'd3, 4'd8, 8'd8,   -1,   1,  20,  4,   2'b00, 29);
      run_txn("big",      4'd15, 4'd14, 8'd255, -1, -1,  0,  4,   2'b00, 9);

      reset_during_push();
      run_txn("after_rst", 4'd3, 4'd7, 8'd10, -1,  -1,   0,  4,   2'b00, 9);

`ifdef STEAL_TIMEOUT_EN
      run_timeout();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
